// File: rtl/pc_gen.sv
// Instruction-fetch PC generator feeding the instruction ROM.
// It handles start-up, stall hold, ID-stage redirect (deferred across stalls),
// exception flush, and flags misaligned fetch addresses.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic [31:0] pc,
  output logic        ce,
  output logic        pc_adel_o
);

  typedef enum logic {
    S_RESET = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  // Only the PC-hold bit of the stall vector matters to this stage.
  logic hold;
  assign hold = stall[0];

  // State register; reset discards any branch parked during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET;
      pc_q       <= RESET_PC;
      ce_q       <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ce_q       <= ce_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Next-state: flush > stall (parking a branch) > branch > parked branch > +4.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ce_d       = ce_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    unique case (state_q)
      S_RESET: begin
        // First enabled fetch is at RESET_PC; all control inputs ignored here.
        state_d = S_RUN;
        ce_d    = 1'b1;
        pc_d    = RESET_PC;
      end
      S_RUN: begin
        ce_d = 1'b1;
        if (flush) begin
          pc_d   = new_pc;
          pend_d = 1'b0;
        end else if (hold) begin
          // A branch resolved while fetch is frozen would be lost; park it.
          if (branch_flag_i) begin
            pend_d     = 1'b1;
            pend_tgt_d = branch_target_address_i;
          end
        end else if (branch_flag_i) begin
          pc_d   = branch_target_address_i;
          pend_d = 1'b0;
        end else if (pend_q) begin
          pc_d   = pend_tgt_q;
          pend_d = 1'b0;
        end else begin
          // Modulo-2^32 increment; wrap is silent and keeps any misalignment.
          pc_d = pc_q + 32'd4;
        end
      end
      default: begin
        state_d = S_RESET;
        ce_d    = 1'b0;
      end
    endcase
  end

  assign pc        = pc_q;
  assign ce        = ce_q;
  // Registered-state only: no input reaches this flag combinationally.
  assign pc_adel_o = ce_q & (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus random traffic against a
// cycle-level reference model of the fetch-address rules.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] pc;
  logic        ce;
  logic        pc_adel_o;

  int nvec = 0;
  int nerr = 0;

  // Reference model state.
  bit          m_run;
  bit          m_ce;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_tgt;

  always #5 clk = ~clk;

  pc_gen #(.RESET_PC(32'h0000_0000)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .pc                      (pc),
    .ce                      (ce),
    .pc_adel_o               (pc_adel_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // What the fetch stage should do on one clock edge, given the inputs.
  task automatic model_edge();
    if (rst) begin
      m_run = 0; m_ce = 0; m_pc = 32'h0; m_pend = 0; m_tgt = 32'h0;
    end else if (!m_run) begin
      m_run = 1; m_ce = 1; m_pc = 32'h0;
    end else if (flush) begin
      m_pc = new_pc; m_pend = 0;
    end else if (stall[0]) begin
      if (branch_flag_i) begin m_pend = 1; m_tgt = branch_target_address_i; end
    end else if (branch_flag_i) begin
      m_pc = branch_target_address_i; m_pend = 0;
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("pc", pc, m_pc);
    chk("ce", {31'b0, ce}, {31'b0, m_ce});
    chk("adel", {31'b0, pc_adel_o}, {31'b0, (m_ce && (m_pc[1:0] != 2'b00))});
  endtask

  task automatic idle();
    rst = 0; stall = '0; flush = 0; new_pc = '0;
    branch_flag_i = 0; branch_target_address_i = '0;
  endtask

  initial begin
    idle();
    m_run = 0; m_ce = 0; m_pc = 0; m_pend = 0; m_tgt = 0;

    // 1: reset then start-up sequence.
    rst = 1;
    repeat (3) tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ce", {31'b0, ce}, 32'h0);
    rst = 0;
    tick();
    chk("start_pc", pc, 32'h0);
    chk("start_ce", {31'b0, ce}, 32'h1);
    tick(); chk("seq4", pc, 32'h4);
    tick(); chk("seq8", pc, 32'h8);

    // 2: branch from 0x10.
    tick(); tick();
    chk("at10", pc, 32'h10);
    branch_flag_i = 1; branch_target_address_i = 32'h100;
    tick(); chk("br100", pc, 32'h100);
    idle();
    tick(); chk("br104", pc, 32'h104);

    // 3: branch arriving during a 3-cycle stall.
    flush = 1; new_pc = 32'h20;
    tick(); idle();
    stall = 6'h01; branch_flag_i = 1; branch_target_address_i = 32'h80;
    tick(); chk("stall_hold0", pc, 32'h20);
    branch_flag_i = 0;
    tick(); tick(); chk("stall_hold2", pc, 32'h20);
    stall = 0;
    tick(); chk("pend80", pc, 32'h80);
    tick(); chk("pend84", pc, 32'h84);

    // 4: flush beats stall and branch together.
    stall = 6'h01; branch_flag_i = 1; branch_target_address_i = 32'h300;
    flush = 1; new_pc = 32'h180;
    tick(); chk("fl180", pc, 32'h180);
    flush = 0; branch_flag_i = 0;
    tick(); chk("fl180_hold", pc, 32'h180);
    stall = 0;
    tick(); chk("fl184", pc, 32'h184);

    // 5: wrap at the top of the address space.
    flush = 1; new_pc = 32'hFFFF_FFF8;
    tick(); idle();
    tick(); chk("wrapFC", pc, 32'hFFFF_FFFC);
    tick(); chk("wrap0", pc, 32'h0);

    // 6: misaligned target, then reset mid-run.
    branch_flag_i = 1; branch_target_address_i = 32'h202;
    tick(); chk("mis202", pc, 32'h202); chk("adel1", {31'b0, pc_adel_o}, 32'h1);
    idle();
    tick(); chk("mis206", pc, 32'h206); chk("adel2", {31'b0, pc_adel_o}, 32'h1);
    rst = 1;
    tick();
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_ce", {31'b0, ce}, 32'h0);
    chk("mrst_adel", {31'b0, pc_adel_o}, 32'h0);
    rst = 0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      stall         = 6'($urandom);
      stall[0]      = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 15) == 0);
      new_pc        = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      branch_flag_i = ($urandom_range(0, 3) == 0);
      branch_target_address_i =
        $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
